// File: rtl/keshe_pkg.sv
// rtl/keshe_pkg.sv - shared mode/state/display encodings and BCD limits for keshe_mode_ctrl
package keshe_pkg;

    localparam logic [1:0] MODE_RUN  = 2'b00;
    localparam logic [1:0] MODE_TSET = 2'b01;
    localparam logic [1:0] MODE_ASET = 2'b10;
    localparam logic [1:0] MODE_CDN  = 2'b11;

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_EDIT   = 2'd1,
        ST_COMMIT = 2'd2,
        ST_FETCH  = 2'd3
    } state_e;

    localparam logic [7:0] HR_MAX = 8'h23;
    localparam logic [7:0] MS_MAX = 8'h59;

    localparam logic [1:0] DSEL_CLK = 2'b00;
    localparam logic [1:0] DSEL_SET = 2'b01;
    localparam logic [1:0] DSEL_ALM = 2'b10;
    localparam logic [1:0] DSEL_CDN = 2'b11;

endpackage

// File: rtl/keshe_bcd_field.sv
// rtl/keshe_bcd_field.sv - one 8-bit BCD up/down counter wrapping between 00 and MAX, with parallel load
module keshe_bcd_field #(
    parameter logic [7:0] MAX = 8'h59
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       up,
    input  logic       dn,
    input  logic       load,
    input  logic [7:0] din,
    output logic [7:0] q
);

    logic [7:0] q_q;
    logic [7:0] q_d;

    // Up and down together cancel, so the field holds.
    always_comb begin
        q_d = q_q;
        if (load) begin
            q_d = din;
        end else if (en && up && !dn) begin
            if (q_q == MAX)              q_d = 8'h00;
            else if (q_q[3:0] == 4'd9)   q_d = {q_q[7:4] + 4'd1, 4'd0};
            else                         q_d = {q_q[7:4], q_q[3:0] + 4'd1};
        end else if (en && dn && !up) begin
            if (q_q == 8'h00)            q_d = MAX;
            else if (q_q[3:0] == 4'd0)   q_d = {q_q[7:4] - 4'd1, 4'd9};
            else                         q_d = {q_q[7:4], q_q[3:0] - 4'd1};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) q_q <= 8'h00;
        else     q_q <= q_d;
    end

    assign q = q_q;

endmodule

// File: rtl/keshe_mode_ctrl.sv
// rtl/keshe_mode_ctrl.sv - panel mode sequencer owning the shared BCD setting register
// Optional edit inactivity timeout is built when KESHE_EDIT_TIMEOUT_EN is defined.
module keshe_mode_ctrl
    import keshe_pkg::*;
#(
    parameter int unsigned TIMEOUT_S = 30
) (
    input  logic       CLK10K,
    input  logic       CR,
    input  logic [1:0] S,
    input  logic       LEAD,
    input  logic       EXPORT,
    input  logic       HU,
    input  logic       HD,
    input  logic       MU,
    input  logic       MD,
    input  logic       SU,
    input  logic       SD,
    input  logic       ADJ_EN,
    input  logic       SEC_EN,
    input  logic [7:0] CLK_H,
    input  logic [7:0] CLK_M,
    input  logic [7:0] CLK_S,
    input  logic [7:0] ALM_H,
    input  logic [7:0] ALM_M,
    input  logic [7:0] ALM_S,
    output logic [7:0] SET_H,
    output logic [7:0] SET_M,
    output logic [7:0] SET_S,
    output logic       LD_CLK,
    output logic       LD_ALM,
    output logic       CD_START,
    output logic       CD_PAUSE,
    output logic [1:0] DSEL,
    output logic       EDIT_ACTIVE
);

    state_e     state_q, state_d;
    logic       lead_q, exp_q;
    logic       ld_clk_q, ld_clk_d;
    logic       ld_alm_q, ld_alm_d;
    logic       cd_start_q, cd_start_d;
    logic       cd_pause_q, cd_pause_d;
    logic       cd_armed_q, cd_armed_d;
    logic [1:0] dsel_q, dsel_d;
    logic       edit_active_q, edit_active_d;

    logic       lead_rise, exp_rise, is_edit, is_cdn, in_strobe;
    logic       adj, fetch_clk, fetch_alm, load;
    logic       timed_out;
    logic [7:0] din_h, din_m, din_s;

    assign lead_rise = LEAD & ~lead_q;
    assign exp_rise  = EXPORT & ~exp_q;
    assign is_edit   = (S == MODE_TSET) || (S == MODE_ASET);
    assign is_cdn    = (S == MODE_CDN);
    assign in_strobe = (state_q == ST_COMMIT) || (state_q == ST_FETCH);

    assign adj       = ADJ_EN && (S != MODE_RUN) && !in_strobe;
    assign fetch_clk = (state_q == ST_FETCH) && (S == MODE_TSET);
    assign fetch_alm = (state_q == ST_FETCH) && (S == MODE_ASET);
    assign load      = fetch_clk || fetch_alm;
    assign din_h     = fetch_clk ? CLK_H : ALM_H;
    assign din_m     = fetch_clk ? CLK_M : ALM_M;
    assign din_s     = fetch_clk ? CLK_S : ALM_S;

`ifdef KESHE_EDIT_TIMEOUT_EN
    localparam int unsigned IW = $clog2(TIMEOUT_S + 1);
    logic [IW-1:0] idle_q, idle_d;
    logic [1:0]    s_q;
    logic          activity;

    assign activity = HU | HD | MU | MD | SU | SD | lead_rise | exp_rise | (S != s_q);

    // Saturates at the limit so a long idle stays timed out until the next activity.
    always_comb begin
        idle_d = idle_q;
        if (!is_edit || activity)
            idle_d = '0;
        else if (SEC_EN && (idle_q < IW'(TIMEOUT_S)))
            idle_d = idle_q + 1'b1;
    end

    assign timed_out = (idle_d >= IW'(TIMEOUT_S));
`else
    logic unused_timeout;
    assign unused_timeout = SEC_EN ^ TIMEOUT_S[0];
    assign timed_out      = 1'b0;
`endif

    always_comb begin
        state_d    = ST_RUN;
        ld_clk_d   = 1'b0;
        ld_alm_d   = 1'b0;
        case (state_q)
            ST_RUN, ST_EDIT: begin
                if (is_edit) begin
                    if (lead_rise) begin
                        state_d  = ST_COMMIT;
                        ld_clk_d = (S == MODE_TSET);
                        ld_alm_d = (S == MODE_ASET);
                    end else if (exp_rise) begin
                        state_d = ST_FETCH;
                    end else begin
                        state_d = ST_EDIT;
                    end
                end
            end
            default: state_d = is_edit ? ST_EDIT : ST_RUN;
        endcase

        cd_start_d    = is_cdn && lead_rise;
        cd_armed_d    = is_cdn && (cd_armed_q || cd_start_d);
        cd_pause_d    = cd_armed_d && EXPORT;
        edit_active_d = is_edit ? !timed_out : is_cdn;
        if (is_edit)
            dsel_d = edit_active_d ? DSEL_SET : DSEL_CLK;
        else
            dsel_d = cd_armed_d ? DSEL_CDN : DSEL_CLK;
    end

    always_ff @(posedge CLK10K) begin
        if (CR) begin
            state_q       <= ST_RUN;
            lead_q        <= 1'b0;
            exp_q         <= 1'b0;
            ld_clk_q      <= 1'b0;
            ld_alm_q      <= 1'b0;
            cd_start_q    <= 1'b0;
            cd_pause_q    <= 1'b0;
            cd_armed_q    <= 1'b0;
            dsel_q        <= DSEL_CLK;
            edit_active_q <= 1'b0;
`ifdef KESHE_EDIT_TIMEOUT_EN
            idle_q        <= '0;
            s_q           <= MODE_RUN;
`endif
        end else begin
            state_q       <= state_d;
            lead_q        <= LEAD;
            exp_q         <= EXPORT;
            ld_clk_q      <= ld_clk_d;
            ld_alm_q      <= ld_alm_d;
            cd_start_q    <= cd_start_d;
            cd_pause_q    <= cd_pause_d;
            cd_armed_q    <= cd_armed_d;
            dsel_q        <= dsel_d;
            edit_active_q <= edit_active_d;
`ifdef KESHE_EDIT_TIMEOUT_EN
            idle_q        <= idle_d;
            s_q           <= S;
`endif
        end
    end

    keshe_bcd_field #(.MAX(HR_MAX)) u_hour (
        .clk(CLK10K), .rst(CR), .en(adj), .up(HU), .dn(HD),
        .load(load), .din(din_h), .q(SET_H)
    );

    keshe_bcd_field #(.MAX(MS_MAX)) u_min (
        .clk(CLK10K), .rst(CR), .en(adj), .up(MU), .dn(MD),
        .load(load), .din(din_m), .q(SET_M)
    );

    keshe_bcd_field #(.MAX(MS_MAX)) u_sec (
        .clk(CLK10K), .rst(CR), .en(adj), .up(SU), .dn(SD),
        .load(load), .din(din_s), .q(SET_S)
    );

    assign LD_CLK      = ld_clk_q;
    assign LD_ALM      = ld_alm_q;
    assign CD_START    = cd_start_q;
    assign CD_PAUSE    = cd_pause_q;
    assign DSEL        = dsel_q;
    assign EDIT_ACTIVE = edit_active_q;

endmodule

// File: tb/tb_keshe_mode_ctrl.sv
// tb/tb_keshe_mode_ctrl.sv - vector table, corner sequences and randomized model check of keshe_mode_ctrl
module tb_keshe_mode_ctrl;

    logic       CLK10K = 1'b0;
    logic       CR, LEAD, EXPORT, HU, HD, MU, MD, SU, SD, ADJ_EN, SEC_EN;
    logic [1:0] S;
    logic [7:0] CLK_H, CLK_M, CLK_S, ALM_H, ALM_M, ALM_S;
    logic [7:0] SET_H, SET_M, SET_S;
    logic       LD_CLK, LD_ALM, CD_START, CD_PAUSE, EDIT_ACTIVE;
    logic [1:0] DSEL;

    keshe_mode_ctrl #(.TIMEOUT_S(3)) dut (
        .CLK10K(CLK10K), .CR(CR), .S(S), .LEAD(LEAD), .EXPORT(EXPORT),
        .HU(HU), .HD(HD), .MU(MU), .MD(MD), .SU(SU), .SD(SD),
        .ADJ_EN(ADJ_EN), .SEC_EN(SEC_EN),
        .CLK_H(CLK_H), .CLK_M(CLK_M), .CLK_S(CLK_S),
        .ALM_H(ALM_H), .ALM_M(ALM_M), .ALM_S(ALM_S),
        .SET_H(SET_H), .SET_M(SET_M), .SET_S(SET_S),
        .LD_CLK(LD_CLK), .LD_ALM(LD_ALM), .CD_START(CD_START), .CD_PAUSE(CD_PAUSE),
        .DSEL(DSEL), .EDIT_ACTIVE(EDIT_ACTIVE)
    );

    always #5 CLK10K = ~CLK10K;

    localparam logic [5:0] K_HU = 6'b100000, K_HD = 6'b010000, K_MU = 6'b001000;
    localparam logic [5:0] K_MD = 6'b000100, K_SU = 6'b000010, K_SD = 6'b000001;

    typedef struct {
        logic [1:0]  s;
        logic        lead;
        logic        exp;
        logic [5:0]  keys;
        logic        adj;
        logic [23:0] set;
        logic [3:0]  str;
        logic [1:0]  dsel;
        logic        ea;
    } vec_t;

    vec_t vecs[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model: time fields as plain integers, one "busy" cycle after a button event.
    int  m_h, m_m, m_s;
    bit  m_lead, m_exp, m_busy, m_fetch, m_armed;
    bit  e_ldc, e_lda, e_cds, e_cdp, e_ea;
    int  e_dsel;

    function automatic int step(int v, bit up, bit dn, int modulus);
        if (up && !dn) return (v + 1) % modulus;
        if (dn && !up) return (v + modulus - 1) % modulus;
        return v;
    endfunction

    function automatic logic [7:0] bcd(int v);
        return 8'(((v / 10) * 16) + (v % 10));
    endfunction

    function automatic int unbcd(logic [7:0] b);
        return int'(b[7:4]) * 10 + int'(b[3:0]);
    endfunction

    task automatic model_edge();
        bit lr, er, ed, nb, nf;
        if (CR) begin
            m_h = 0; m_m = 0; m_s = 0;
            m_lead = 0; m_exp = 0; m_busy = 0; m_fetch = 0; m_armed = 0;
            e_ldc = 0; e_lda = 0; e_cds = 0; e_cdp = 0; e_ea = 0; e_dsel = 0;
            return;
        end
        lr = LEAD && !m_lead;
        er = EXPORT && !m_exp;
        ed = (S == 2'd1) || (S == 2'd2);
        e_ldc = 0; e_lda = 0; e_cds = 0;
        if (m_fetch && ed) begin
            m_h = unbcd(S == 2'd1 ? CLK_H : ALM_H);
            m_m = unbcd(S == 2'd1 ? CLK_M : ALM_M);
            m_s = unbcd(S == 2'd1 ? CLK_S : ALM_S);
        end
        if (ADJ_EN && S != 2'd0 && !m_busy) begin
            m_h = step(m_h, HU, HD, 24);
            m_m = step(m_m, MU, MD, 60);
            m_s = step(m_s, SU, SD, 60);
        end
        nb = 0; nf = 0;
        if (ed && !m_busy) begin
            if (lr) begin
                e_ldc = (S == 2'd1); e_lda = (S == 2'd2); nb = 1;
            end else if (er) begin
                nf = 1; nb = 1;
            end
        end
        m_busy = nb; m_fetch = nf;
        e_cds   = (S == 2'd3) && lr;
        m_armed = (S == 2'd3) && (m_armed || e_cds);
        e_cdp   = m_armed && EXPORT;
        e_ea    = (S != 2'd0);
        e_dsel  = ed ? 1 : (m_armed ? 3 : 0);
        m_lead = LEAD; m_exp = EXPORT;
    endtask

    task automatic tick();
        model_edge();
        @(posedge CLK10K);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [23:0] set, input logic [3:0] str,
                           input logic [1:0] dsel, input logic ea);
        chk({tag, " set"},     32'({SET_H, SET_M, SET_S}), 32'(set));
        chk({tag, " strobes"}, 32'({LD_CLK, LD_ALM, CD_START, CD_PAUSE}), 32'(str));
        chk({tag, " dsel"},    32'(DSEL), 32'(dsel));
        chk({tag, " edit"},    32'(EDIT_ACTIVE), 32'(ea));
    endtask

    task automatic add(input logic [1:0] s, input logic lead, input logic exp, input logic [5:0] keys,
                       input logic adj, input logic [23:0] set, input logic [3:0] str,
                       input logic [1:0] dsel, input logic ea);
        vec_t v;
        v.s = s; v.lead = lead; v.exp = exp; v.keys = keys; v.adj = adj;
        v.set = set; v.str = str; v.dsel = dsel; v.ea = ea;
        vecs.push_back(v);
    endtask

    task automatic idle_inputs();
        LEAD = 0; EXPORT = 0; {HU, HD, MU, MD, SU, SD} = 6'b0; ADJ_EN = 0; SEC_EN = 0;
    endtask

    initial begin
        int pause_cnt;
        bit exp_ea_to;
        logic [1:0] exp_dsel_to;

        CR = 1; S = 2'd0; idle_inputs();
        CLK_H = 8'h12; CLK_M = 8'h34; CLK_S = 8'h56;
        ALM_H = 8'h07; ALM_M = 8'h30; ALM_S = 8'h00;
        tick(); tick();
        chk_all("reset", 24'h000000, 4'b0000, 2'b00, 1'b0);
        CR = 0;

        // s, lead, exp, keys, adj -> set, {ldc,lda,cds,cdp}, dsel, edit
        add(1, 0, 0, 0,         0, 24'h000000, 4'b0000, 1, 1);
        for (int i = 1; i <= 3; i++) add(1, 0, 0, K_SU, 1, 24'(i), 4'b0000, 1, 1);
        add(1, 0, 0, K_SU,      0, 24'h000003, 4'b0000, 1, 1);
        add(1, 0, 0, K_MD,      1, 24'h005903, 4'b0000, 1, 1);
        add(1, 0, 0, K_MU,      1, 24'h000003, 4'b0000, 1, 1);
        add(1, 0, 0, K_HD,      1, 24'h230003, 4'b0000, 1, 1);
        add(1, 0, 0, K_HU | K_HD | K_SD, 1, 24'h230002, 4'b0000, 1, 1);
        add(1, 0, 0, K_HU,      1, 24'h000002, 4'b0000, 1, 1);
        for (int i = 0; i < 10; i++) add(1, 1, 0, 0, 0, 24'h000002, (i == 0) ? 4'b1000 : 4'b0000, 1, 1);
        add(1, 0, 0, 0,         0, 24'h000002, 4'b0000, 1, 1);
        add(2, 0, 0, 0,         0, 24'h000002, 4'b0000, 1, 1);
        for (int i = 0; i < 10; i++) add(2, 1, 0, 0, 0, 24'h000002, (i == 0) ? 4'b0100 : 4'b0000, 1, 1);
        add(2, 0, 0, 0,         0, 24'h000002, 4'b0000, 1, 1);
        add(2, 0, 1, 0,         0, 24'h000002, 4'b0000, 1, 1);
        add(2, 0, 1, 0,         0, 24'h073000, 4'b0000, 1, 1);
        add(2, 0, 0, 0,         0, 24'h073000, 4'b0000, 1, 1);
        add(2, 0, 0, K_SU,      1, 24'h073001, 4'b0000, 1, 1);
        add(2, 1, 1, 0,         0, 24'h073001, 4'b0100, 1, 1);
        add(2, 1, 1, 0,         0, 24'h073001, 4'b0000, 1, 1);
        add(2, 0, 0, 0,         0, 24'h073001, 4'b0000, 1, 1);
        add(1, 0, 1, 0,         0, 24'h073001, 4'b0000, 1, 1);
        add(1, 0, 0, 0,         0, 24'h123456, 4'b0000, 1, 1);
        add(1, 1, 0, K_SU,      1, 24'h123457, 4'b1000, 1, 1);
        add(1, 1, 0, K_SU,      1, 24'h123457, 4'b0000, 1, 1);
        add(1, 0, 0, K_SU,      1, 24'h123458, 4'b0000, 1, 1);
        add(1, 0, 1, K_SU,      1, 24'h123459, 4'b0000, 1, 1);
        add(1, 0, 1, K_SU,      1, 24'h123456, 4'b0000, 1, 1);
        add(1, 0, 0, 0,         0, 24'h123456, 4'b0000, 1, 1);
        add(1, 0, 0, K_SU,      1, 24'h123457, 4'b0000, 1, 1);
        add(1, 0, 0, K_SU,      1, 24'h123458, 4'b0000, 1, 1);
        add(1, 0, 0, K_SU,      1, 24'h123459, 4'b0000, 1, 1);
        add(1, 0, 0, K_SU,      1, 24'h123400, 4'b0000, 1, 1);
        add(0, 0, 0, 0,         0, 24'h123400, 4'b0000, 0, 0);
        add(0, 1, 1, K_SU | K_HU, 1, 24'h123400, 4'b0000, 0, 0);
        add(0, 0, 0, 0,         0, 24'h123400, 4'b0000, 0, 0);

        foreach (vecs[i]) begin
            S = vecs[i].s; LEAD = vecs[i].lead; EXPORT = vecs[i].exp;
            {HU, HD, MU, MD, SU, SD} = vecs[i].keys; ADJ_EN = vecs[i].adj;
            tick();
            chk_all($sformatf("vec%0d", i), vecs[i].set, vecs[i].str, vecs[i].dsel, vecs[i].ea);
        end
        idle_inputs();

        // Countdown: pause only after a start, tracks EXPORT level, clears when leaving mode 11.
        S = 2'd3; EXPORT = 1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk_all("cd_prestart", 24'h123400, 4'b0000, 2'b00, 1'b1);
        end
        EXPORT = 0; tick();
        LEAD = 1;   tick(); chk_all("cd_start", 24'h123400, 4'b0010, 2'b11, 1'b1);
        tick();             chk_all("cd_start_held", 24'h123400, 4'b0000, 2'b11, 1'b1);
        LEAD = 0;   tick();
        pause_cnt = 0;
        EXPORT = 1;
        for (int i = 0; i < 80; i++) begin
            tick();
            if (CD_PAUSE) pause_cnt++;
            chk("cd_pause_hold", 32'(CD_PAUSE), 32'd1);
        end
        EXPORT = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (CD_PAUSE) pause_cnt++;
        end
        chk("cd_pause_count", 32'(pause_cnt), 32'd80);
        EXPORT = 1; tick(); chk("cd_pause_again", 32'(CD_PAUSE), 32'd1);
        S = 2'd0;   tick(); chk_all("cd_leave", 24'h123400, 4'b0000, 2'b00, 1'b0);
        S = 2'd3;   tick(); chk_all("cd_reenter", 24'h123400, 4'b0000, 2'b00, 1'b1);
        idle_inputs();

        // Reset on the same edge as a LEAD rise must suppress the strobe.
        S = 2'd1; tick();
        LEAD = 1; CR = 1; tick();
        chk_all("reset_strobe", 24'h000000, 4'b0000, 2'b00, 1'b0);
        LEAD = 0; tick();
        CR = 0; S = 2'd0; tick();

        // Inactivity timeout with TIMEOUT_S = 3.
`ifdef KESHE_EDIT_TIMEOUT_EN
        exp_ea_to = 1'b0; exp_dsel_to = 2'b00;
`else
        exp_ea_to = 1'b1; exp_dsel_to = 2'b01;
`endif
        S = 2'd1; tick();
        for (int p = 1; p <= 3; p++) begin
            SEC_EN = 1; tick(); SEC_EN = 0;
            if (p < 3) chk_all($sformatf("to_sec%0d", p), 24'h000000, 4'b0000, 2'b01, 1'b1);
            else       chk_all("to_expired", 24'h000000, 4'b0000, exp_dsel_to, exp_ea_to);
            tick(); tick();
        end
        chk_all("to_idle", 24'h000000, 4'b0000, exp_dsel_to, exp_ea_to);
        SU = 1; ADJ_EN = 1; tick();
        chk_all("to_wake", 24'h000001, 4'b0000, 2'b01, 1'b1);
        idle_inputs(); tick();

        // Randomized run against the reference model.
        CR = 1; tick(); CR = 0;
        for (int c = 0; c < 3000; c++) begin
            CR = ($urandom_range(0, 299) == 0);
            if ($urandom_range(0, 39) == 0) S = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 3) == 0) LEAD = ~LEAD;
            if ($urandom_range(0, 3) == 0) EXPORT = ~EXPORT;
            HU = ($urandom_range(0, 3) == 0); HD = ($urandom_range(0, 3) == 0);
            MU = ($urandom_range(0, 3) == 0); MD = ($urandom_range(0, 3) == 0);
            SU = ($urandom_range(0, 3) == 0); SD = ($urandom_range(0, 3) == 0);
            ADJ_EN = ($urandom_range(0, 2) == 0);
`ifdef KESHE_EDIT_TIMEOUT_EN
            SEC_EN = 0;
`else
            SEC_EN = ($urandom_range(0, 4) == 0);
`endif
            if ($urandom_range(0, 15) == 0) begin
                CLK_H = bcd($urandom_range(0, 23)); CLK_M = bcd($urandom_range(0, 59));
                CLK_S = bcd($urandom_range(0, 59)); ALM_H = bcd($urandom_range(0, 23));
                ALM_M = bcd($urandom_range(0, 59)); ALM_S = bcd($urandom_range(0, 59));
            end
            tick();
            chk_all($sformatf("rnd%0d", c), {bcd(m_h), bcd(m_m), bcd(m_s)},
                    {e_ldc, e_lda, e_cds, e_cdp}, 2'(e_dsel), e_ea);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
